// File: rtl/ram_copier.sv
// DMA copy engine for the shared 32-bit byte-enable RAM port.
// Copies words or bytes from src to dst, one read/write pair per element, arbitrated via req/gnt.
module ram_copier #(
    parameter int unsigned num_kbytes = 128,
    parameter int unsigned len_width  = 16,
    localparam int unsigned addr_width = $clog2(num_kbytes * 'h400)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  bmode,
    input  logic [addr_width-1:0] src,
    input  logic [addr_width-1:0] dst,
    input  logic [len_width-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [len_width-1:0]  remaining,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_wr,
    output logic                  mem_be,
    output logic [addr_width-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StDone} state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] src_q, dst_q;
    logic [len_width-1:0]  rem_q;
    logic                  bmode_q;
    logic                  abort_q;
    logic [31:0]           data_q;
    logic [addr_width-1:0] step;
    logic                  stop;
    logic [7:0]            sel_byte;

    assign step      = bmode_q ? addr_width'(1) : addr_width'(4);
    // An abort seen earlier in the transfer is held until the current pair completes.
    assign stop      = abort | abort_q;
    assign sel_byte  = data_q[{src_q[1:0], 3'b000} +: 8];
    assign remaining = rem_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) state_d = (len == '0) ? StDone : StReq;
            end
            StReq: begin
                if (stop)         state_d = StDone;
                else if (mem_gnt) state_d = StRd;
            end
            StRd:   state_d = StWr;
            StWr: begin
                if (rem_q == len_width'(1) || stop) state_d = StDone;
                else if (mem_gnt)                   state_d = StRd;
                else                                state_d = StReq;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_req   = (state_q == StReq) || (state_q == StRd) || (state_q == StWr);
        mem_wr    = (state_q == StWr);
        mem_be    = (state_q == StWr) && bmode_q;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == StRd) begin
            mem_addr = src_q;
        end else if (state_q == StWr) begin
            mem_addr  = dst_q;
            mem_wdata = bmode_q ? (32'(sel_byte) << {dst_q[1:0], 3'b000}) : data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            bmode_q <= 1'b0;
            abort_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        bmode_q <= bmode;
                        src_q   <= bmode ? src : {src[addr_width-1:2], 2'b00};
                        dst_q   <= bmode ? dst : {dst[addr_width-1:2], 2'b00};
                        rem_q   <= len;
                    end
                end
                StRd: data_q <= mem_rdata;
                StWr: begin
                    rem_q <= rem_q - len_width'(1);
                    src_q <= src_q + step;
                    dst_q <= dst_q + step;
                end
                default: ;
            endcase
            if (mem_req && abort)      abort_q <= 1'b1;
            else if (state_q == StDone) abort_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_copier.sv
// Bench for ram_copier: byte-array RAM, directed vector table and random copies
// checked against a sequential element-by-element copy model.
module tb_ram_copier;

    localparam int AW  = 17;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          bmode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [15:0]   len = '0;
    logic          busy, done;
    logic [15:0]   remaining;
    logic          mem_req, mem_gnt, mem_wr, mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          gnt_val = 1'b1;

    logic [7:0]    ram    [MSZ];
    logic [7:0]    shadow [MSZ];
    logic [AW-1:0] ra;
    logic [AW-1:0] wl_addr [1024];
    logic [31:0]   wl_data [1024];
    logic          wl_be   [1024];
    int            wcount;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic          bm;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        int            n;
        int            stall_at;
        int            stall_len;
        int            abort_at;
        int            rst_at;
        int            poke_at;
        int            exp_done;  // -1: don't care, 0: no done pulse expected
        int            exp_rem;
        int            exp_wr;
    } vec_t;

    ram_copier dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .bmode     (bmode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_wr    (mem_wr),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_gnt   = gnt_val;
    assign ra        = {mem_addr[AW-1:2], 2'b00};
    assign mem_rdata = {ram[ra+3], ram[ra+2], ram[ra+1], ram[ra]};

    // RAM: writes land mid-cycle, so the read of a later cycle sees them.
    initial begin
        wcount = 0;
        for (int i = 0; i < MSZ; i++) ram[i] = 8'($urandom);
        forever begin
            @(negedge clk);
            if (mem_wr) begin
                wl_addr[wcount % 1024] = mem_addr;
                wl_data[wcount % 1024] = mem_wdata;
                wl_be[wcount % 1024]   = mem_be;
                wcount++;
                if (mem_be) ram[mem_addr] = mem_wdata[8*mem_addr[1:0] +: 8];
                else for (int b = 0; b < 4; b++) ram[ra+b] = mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic bm, input int s, input int d, input int n,
                                input int stall_at, input int stall_len, input int abort_at,
                                input int rst_at, input int poke_at, input int exp_done,
                                input int exp_rem, input int exp_wr);
        vec_t v;
        v.bm = bm; v.s = AW'(s); v.d = AW'(d); v.n = n;
        v.stall_at = stall_at; v.stall_len = stall_len; v.abort_at = abort_at;
        v.rst_at = rst_at; v.poke_at = poke_at;
        v.exp_done = exp_done; v.exp_rem = exp_rem; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic run(input vec_t v, input bit rnd_gnt);
        int            k, base, done_at, busy_cnt, req_cnt, viol, stop_k, nw, bad, stp;
        logic [AW-1:0] sa, da;
        logic [31:0]   ed;
        base = wcount; done_at = 0; busy_cnt = 0; req_cnt = 0; viol = 0;
        start = 1'b1; bmode = v.bm; src = v.s; dst = v.d; len = 16'(v.n);
        abort = 1'b0; gnt_val = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        stop_k = (v.rst_at > 0) ? v.rst_at + 4 : 300;
        while (k <= stop_k) begin
            gnt_val = rnd_gnt ? ($urandom_range(0, 3) != 0)
                              : !(k >= v.stall_at && k < v.stall_at + v.stall_len);
            abort = (k == v.abort_at);
            rst   = (k == v.rst_at);
            start = (k == v.poke_at);
            if (k == v.poke_at) begin
                len = 16'd9;
                dst = '0;
            end
            if (busy) busy_cnt++;
            if (mem_req) req_cnt++;
            if (busy && !done && !mem_req) viol++;
            if (mem_wr && !mem_req) viol++;
            if (v.rst_at > 0 && k == v.rst_at + 1) begin
                check("reset_mid_wr", mem_wr, 0);
                check("reset_mid_busy", busy, 0);
            end
            if (done && done_at == 0) done_at = k;
            if (done_at != 0 && k == done_at + 1) begin
                check("post_done_idle", {busy, done}, 0);
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        abort = 1'b0; rst = 1'b0; start = 1'b0; gnt_val = 1'b1;

        if (v.exp_done >= 0) check("done_cycle", done_at, v.exp_done);
        check("remaining", remaining, v.exp_rem);
        check("bus_rules", viol, 0);
        if (v.n == 0) begin
            check("len0_req", req_cnt, 0);
            check("len0_busy", busy_cnt, 1);
        end
        nw = wcount - base;
        check("write_count", nw, v.exp_wr);

        // Reference: ascending element-by-element copy on the shadow image.
        stp = v.bm ? 1 : 4;
        sa = v.bm ? v.s : {v.s[AW-1:2], 2'b00};
        da = v.bm ? v.d : {v.d[AW-1:2], 2'b00};
        for (int i = 0; i < v.exp_wr; i++) begin
            if (v.bm) begin
                ed = 32'(shadow[sa]) << (8 * da[1:0]);
                shadow[da] = shadow[sa];
            end else begin
                ed = {shadow[sa+3], shadow[sa+2], shadow[sa+1], shadow[sa]};
                for (int b = 0; b < 4; b++) shadow[da+b] = ed[8*b +: 8];
            end
            if (i < nw)
                check("write", {wl_be[(base+i)%1024], wl_addr[(base+i)%1024],
                                wl_data[(base+i)%1024]}, {v.bm, da, ed});
            sa = sa + AW'(stp);
            da = da + AW'(stp);
        end
        bad = 0;
        for (int i = 0; i < MSZ; i++) if (ram[i] !== shadow[i]) bad++;
        check("ram_image", bad, 0);
        if (bad != 0) for (int i = 0; i < MSZ; i++) shadow[i] = ram[i];
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[11];
        vec_t rv;
        int   bs, ws;
        //          bm    src       dst       n  stl sln abt rst pok done rem wr
        tbl[0]  = mk(1'b0, 'h100,   'h200,    4, 0,  0,  0,  0,  2,  10,  0,  4);
        tbl[1]  = mk(1'b1, 'h101,   'h302,    3, 0,  0,  0,  0,  0,  8,   0,  3);
        tbl[2]  = mk(1'b0, 'h100,   'h200,    4, 5,  5,  0,  0,  0,  15,  0,  4);
        tbl[3]  = mk(1'b0, 'h100,   'h200,    0, 0,  0,  0,  0,  0,  1,   0,  0);
        tbl[4]  = mk(1'b0, 'h400,   'h800,    8, 0,  0,  4,  0,  0,  6,   6,  2);
        tbl[5]  = mk(1'b0, 'h040,   'h1FFFC,  2, 0,  0,  0,  0,  0,  6,   0,  2);
        tbl[6]  = mk(1'b1, 'h500,   'h501,    5, 0,  0,  0,  0,  0,  12,  0,  5);
        tbl[7]  = mk(1'b0, 'h603,   'h707,    2, 0,  0,  0,  0,  0,  6,   0,  2);
        tbl[8]  = mk(1'b0, 'h100,   'h900,    3, 1,  10, 2,  0,  0,  3,   3,  0);
        tbl[9]  = mk(1'b0, 'h100,   'hA00,    4, 0,  0,  0,  3,  0,  0,   0,  1);
        tbl[10] = mk(1'b1, 'h1FFFF, 'h010,    3, 0,  0,  0,  0,  0,  8,   0,  3);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_req", {mem_req, mem_wr, mem_be}, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_remaining", remaining, 0);
        for (int i = 0; i < MSZ; i++) shadow[i] = ram[i];

        foreach (tbl[i]) run(tbl[i], 1'b0);

        // start together with abort is dropped.
        ws = wcount;
        bs = 0;
        start = 1'b1; abort = 1'b1; len = 16'd5; bmode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (busy || mem_req) bs++;
            @(posedge clk); #1;
        end
        check("start_abort_idle", bs, 0);
        check("start_abort_writes", wcount - ws, 0);

        for (int r = 0; r < 20; r++) begin
            rv = mk(1'($urandom), int'($urandom_range(0, MSZ - 1)),
                    int'($urandom_range(0, MSZ - 1)), int'($urandom_range(1, 12)),
                    0, 0, 0, 0, 0, -1, 0, 0);
            rv.exp_wr = rv.n;
            run(rv, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
